// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiplier / restoring divider with HI/LO result registers
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2*WIDTH:0] acc, acc_nx;
    logic [WIDTH-1:0] a, s1, mag1, mag2, quot, rem;
    logic [WIDTH:0] mul_hi;
    logic [WIDTH+1:0] trial;
    logic [2*WIDTH-1:0] prod;
    logic is_div, dz, neg_q, neg_r, sgn1, sgn2, launch;

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = (state == CALC) ? ((cnt == CW'(WIDTH-1)) ? FIX : CALC) :
                   (state == FIX)  ? DONE :
                   (start_i ? CALC : IDLE);
    end

    always_comb begin
        busy_o = (state == CALC) || (state == FIX);
        done_o = (state == DONE);
    end

    always_comb begin
        launch = ((state == IDLE) || (state == DONE)) && start_i;
        sgn1   = op_i[0] & src1_i[WIDTH-1];
        sgn2   = op_i[0] & src2_i[WIDTH-1];
        mag1   = sgn1 ? -src1_i : src1_i;
        mag2   = sgn2 ? -src2_i : src2_i;
        mul_hi = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, a} : '0);
        // trial subtract on the remainder after the left shift; MSB is the borrow
        trial  = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, a};
        acc_nx = !is_div ? {1'b0, mul_hi, acc[WIDTH-1:1]} :
                 trial[WIDTH+1] ? {acc[2*WIDTH-1:0], 1'b0} :
                 {trial[WIDTH:0], acc[WIDTH-2:0], 1'b1};
        prod   = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        quot   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            is_div <= 1'b0;
            dz     <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a      <= '0;
            s1     <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else if (launch) begin
            is_div <= op_i[1];
            dz     <= op_i[1] && (src2_i == '0);
            neg_q  <= sgn1 ^ sgn2;
            neg_r  <= sgn1;
            a      <= op_i[1] ? mag2 : mag1;
            s1     <= src1_i;
            acc    <= {{(WIDTH+1){1'b0}}, op_i[1] ? mag1 : mag2};
            cnt    <= '0;
        end else if (state == CALC) begin
            acc    <= acc_nx;
            cnt    <= cnt + 1'b1;
        end else if (state == FIX) begin
            // divide by zero bypasses sign fix-up: quotient all ones, remainder is the raw dividend
            hi_o   <= dz ? s1 : is_div ? rem : prod[2*WIDTH-1:WIDTH];
            lo_o   <= dz ? '1 : is_div ? quot : prod[WIDTH-1:0];
        end
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage of the CPU datapath.
- Its hi_o/lo_o outputs feed the write-back select mux: lo_o drives data2_i, and the ALU result and memory data drive the other inputs.
- It accepts one operation on start_i and computes it over WIDTH+1 busy cycles.
- It holds the result in HI/LO registers until the next operation.

Parameters:
- WIDTH, 32, operand width. Product is 2*WIDTH bits, split across hi_o/lo_o. Must be >= 2.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  launch request; sampled on rising clk_i.
- op_i  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- src1_i  input  WIDTH  multiplicand / dividend.
- src2_i  input  WIDTH  multiplier / divisor.
- busy_o  output  1  high while an operation is in flight.
- done_o  output  1  one-cycle pulse when hi_o/lo_o are updated.
- hi_o  output  WIDTH  MUL: product[2W-1:W]; DIV: remainder.
- lo_o  output  WIDTH  MUL: product[W-1:0]; DIV: quotient.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; busy_o=0, done_o=0, hi_o=0, lo_o=0; counter and internal registers=0.
  - Reset mid-operation aborts the operation with no result written.
  - Release is synchronous to the next clk_i edge.
- States: IDLE, CALC, FIX, DONE. busy_o=1 in CALC and FIX only. done_o=1 in DONE only.
- IDLE or DONE with start_i=1 at edge E0:
  - Latch op_i, src1_i, src2_i.
  - For signed ops, take magnitudes and record result signs.
  - Clear counter; go to CALC.
- IDLE or DONE with start_i=0: go to or stay in IDLE. hi_o/lo_o hold.
- CALC: one iteration per edge, WIDTH edges (E0+1 .. E0+WIDTH), then FIX.
  - MUL is shift-add: if the multiplier LSB is set, add the multiplicand to the upper accumulator half; then shift right one with carry.
  - DIV is restoring: shift {rem,quot} left one; trial-subtract the divisor from rem; if there is no borrow, keep the difference and set the quotient LSB.
  - Internal accumulator is 2*WIDTH+1 bits; no overflow is possible.
- FIX: one edge, E0+WIDTH+1. Apply signs and write hi_o/lo_o, then go to DONE.
  - MULT: negate the 2W-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Latency: hi_o/lo_o are valid and done_o=1 in the cycle after edge E0+WIDTH+1. busy_o is high for exactly WIDTH+1 cycles.
- start_i while busy_o=1 is ignored; no queueing.
- The CPU stalls on (busy_o | start_i).
- Divide by zero (src2_i=0, DIVU or DIV):
  - lo_o = all ones; hi_o = src1_i unmodified.
  - Full latency is still taken; the FIX sign step is bypassed.
- Signed overflow, DIV of the most-negative value by -1:
  - lo_o = most-negative value (0x80000000 at WIDTH=32); hi_o=0.
  - This falls out of the magnitude arithmetic and must not be special-cased wrongly.
- MULT with the most-negative value squared: the 2W-bit result is exact (0x4000000000000000 at WIDTH=32).
- Back-to-back: start_i=1 in DONE starts the next operation on that same edge. done_o still pulses exactly one cycle.
- Operand changes after E0 have no effect.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF x 0xFFFFFFFF:
  - busy_o high for 33 cycles.
  - Then hi_o=0xFFFFFFFE, lo_o=0x00000001, done_o pulses for 1 cycle.
- MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB (-21).
  - Then MULT 0x80000000 x 0x80000000 -> hi_o=0x40000000, lo_o=0x00000000.
- DIVU 100/7 -> lo_o=14, hi_o=2.
  - DIV 0xFFFFFF9C (-100) / 7 -> lo_o=0xFFFFFFF2 (-14), hi_o=0xFFFFFFFE (-2).
  - DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIVU 1234/0 and DIV 0xFFFFFFFF/0 -> lo_o=0xFFFFFFFF; hi_o=1234 and 0xFFFFFFFF respectively; latency unchanged.
- Pulse start_i again at cycle 10 of a busy operation with different operands -> ignored; the first result is unaffected.
  - Then assert start_i in the DONE cycle -> a new operation begins that edge; busy_o rises the next cycle.
- Assert rst_i=0 asynchronously mid-CALC (between edges) -> outputs go to 0 immediately, without waiting for a clock edge.
  - After release, state is IDLE; a fresh MULTU 3x5 gives lo_o=15, hi_o=0.
